// File: rtl/piso_serial_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package piso_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Bit-cell divider: pulses tick on the last cycle of each CLK_DIV-cycle cell while en is high.
module clk_div_tick
  import piso_serial_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            DW   = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // With CLK_DIV=1 the counter is pinned at zero, so tick collapses to en.
  always_ff @(posedge clk) begin
    if (rst || !en || tick) div_cnt <= '0;
    else                    div_cnt <= div_cnt + 1'b1;
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: one word per valid/ready handshake, sent bit-serially
// with frame enable, per-bit strobe and an end-of-frame done pulse.
module piso_serial_tx
  import piso_serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             bit_strobe,
  output logic             done
);

  localparam int            BW       = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || CLK_DIV < 1) begin : g_param_chk
      $error("piso_serial_tx: WIDTH must be >= 2 and CLK_DIV must be >= 1");
    end
  endgenerate

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             ser_out_n, ser_en_n, strobe_n, done_n;
  logic             tick;

  function automatic logic end_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  clk_div_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (state == SHIFT),
    .tick(tick)
  );

  assign tx_ready = (state == IDLE) && !rst;

  // Outputs are registered, so next-cycle values are computed here alongside the next state.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    ser_out_n = 1'b0;
    ser_en_n  = 1'b0;
    strobe_n  = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n   = SHIFT;
          sreg_n    = tx_data;
          bit_cnt_n = '0;
          ser_out_n = end_bit(tx_data);
          ser_en_n  = 1'b1;
          strobe_n  = 1'b1;
        end
      end
      SHIFT: begin
        ser_en_n  = 1'b1;
        ser_out_n = end_bit(sreg);
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_n   = DONE;
            ser_en_n  = 1'b0;
            ser_out_n = 1'b0;
            done_n    = 1'b1;
          end else begin
            sreg_n    = shift_word(sreg);
            bit_cnt_n = bit_cnt + 1'b1;
            ser_out_n = end_bit(sreg_n);
            strobe_n  = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      ser_out    <= 1'b0;
      ser_en     <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      bit_cnt    <= bit_cnt_n;
      ser_out    <= ser_out_n;
      ser_en     <= ser_en_n;
      bit_strobe <= strobe_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: two instances (MSB-first CLK_DIV=1, LSB-first CLK_DIV=3)
// checked cycle by cycle against a timeline model derived from handshake times.
module tb_piso_serial_tx;

  localparam int D0 = 1;
  localparam bit M0 = 1'b1;
  localparam int D1 = 3;
  localparam bit M1 = 1'b0;

  typedef struct {
    bit         v;
    logic [7:0] w;
    int         hs;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data    [2];
  logic       tx_valid   [2];
  logic       tx_ready   [2];
  logic       ser_out    [2];
  logic       ser_en     [2];
  logic       bit_strobe [2];
  logic       done       [2];

  int   cyc = 0;
  int   rf  [2] = '{0, 0};
  int   acc [2] = '{0, 0};
  frm_t q0[$];
  frm_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .CLK_DIV(D0), .MSB_FIRST(M0)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .ser_out(ser_out[0]), .ser_en(ser_en[0]),
    .bit_strobe(bit_strobe[0]), .done(done[0])
  );

  piso_serial_tx #(.WIDTH(8), .CLK_DIV(D1), .MSB_FIRST(M1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .ser_out(ser_out[1]), .ser_en(ser_en[1]),
    .bit_strobe(bit_strobe[1]), .done(done[1])
  );

  // Expected {tx_ready, ser_en, ser_out, bit_strobe, done} for cycle c given the frame in flight.
  function automatic logic [4:0] exp_vec(input frm_t f, input int c, input int d, input bit m,
                                         input bit rdy);
    logic [4:0] e;
    int t, k;
    e = {rdy, 4'b0000};
    if (f.v) begin
      t = c - f.hs;
      if (t >= 1 && t <= 8 * d) begin
        k    = (t - 1) / d;
        e[3] = 1'b1;
        e[2] = m ? f.w[7-k] : f.w[k];
        e[1] = ((t - 1) % d) == 0;
      end else if (t == 8 * d + 1) begin
        e[0] = 1'b1;
      end
    end
    return e;
  endfunction

  task check(input int idx, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d cycle %0d {rdy,en,out,stb,done}: got %b want %b", idx, cyc, act, exp);
    end
  endtask

  // Model side: accept words exactly when the model says the transmitter is idle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q0.delete();
      q1.delete();
      rf[0] <= 0;
      rf[1] <= 0;
    end else begin
      if (tx_valid[0] && q0.size() == 0 && cyc >= rf[0]) begin
        q0.push_back('{1'b1, tx_data[0], cyc});
        rf[0]  <= cyc + 2 + 8 * D0;
        acc[0] <= acc[0] + 1;
      end
      if (tx_valid[1] && q1.size() == 0 && cyc >= rf[1]) begin
        q1.push_back('{1'b1, tx_data[1], cyc});
        rf[1]  <= cyc + 2 + 8 * D1;
        acc[1] <= acc[1] + 1;
      end
    end
  end

  // Monitor: compares every cycle's outputs against the frame at the head of each queue.
  always @(negedge clk) begin
    frm_t       f;
    logic [4:0] e;
    if (cyc >= 1) begin
      f.v = 1'b0; f.w = 8'h00; f.hs = 0;
      if (q0.size() > 0) f = q0[0];
      e = exp_vec(f, cyc, D0, M0, !rst && !f.v && cyc >= rf[0]);
      check(0, {tx_ready[0], ser_en[0], ser_out[0], bit_strobe[0], done[0]}, e);
      if (f.v && cyc - f.hs == 8 * D0 + 1) void'(q0.pop_front());

      f.v = 1'b0; f.w = 8'h00; f.hs = 0;
      if (q1.size() > 0) f = q1[0];
      e = exp_vec(f, cyc, D1, M1, !rst && !f.v && cyc >= rf[1]);
      check(1, {tx_ready[1], ser_en[1], ser_out[1], bit_strobe[1], done[1]}, e);
      if (f.v && cyc - f.hs == 8 * D1 + 1) void'(q1.pop_front());
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold tx_valid until the model records the handshake.
  task automatic send(input int idx, input logic [7:0] w);
    int start, n;
    start         = acc[idx];
    tx_data[idx]  = w;
    tx_valid[idx] = 1'b1;
    n = 0;
    while (acc[idx] == start) begin
      tick_n(1);
      n++;
      if (n > 200) begin
        $display("FAIL handshake_timeout dut%0d: no acceptance after %0d cycles, want <= 200", idx, n);
        $fatal(1, "handshake timeout");
      end
    end
    tx_valid[idx] = 1'b0;
  endtask

  task automatic rnd_run(input int idx, input int cnt);
    int gap;
    for (int i = 0; i < cnt; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) tick_n(gap);
      send(idx, 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    rst         = 1'b1;
    tx_valid[0] = 1'b0;
    tx_valid[1] = 1'b0;
    tx_data[0]  = 8'h00;
    tx_data[1]  = 8'h00;
    tick_n(3);
    rst = 1'b0;
    tick_n(2);

    send(0, 8'hA5);
    tick_n(14);
    send(1, 8'h81);
    tick_n(30);

    // Back-to-back frames with tx_valid held high.
    send(0, 8'h3C);
    send(0, 8'hC3);
    tick_n(14);

    // Data change and valid pulse while a frame is in flight are ignored.
    send(0, 8'h55);
    tick_n(2);
    tx_data[0]  = 8'hAA;
    tx_valid[0] = 1'b1;
    tick_n(1);
    tx_valid[0] = 1'b0;
    tick_n(12);

    // Abort during the 4th bit cell; dut_b sees valid during reset, which must not load.
    send(0, 8'hFF);
    tick_n(3);
    rst         = 1'b1;
    tx_data[1]  = 8'h99;
    tx_valid[1] = 1'b1;
    tick_n(2);
    rst = 1'b0;
    send(1, 8'h99);
    send(0, 8'h0F);
    tick_n(30);

    fork
      rnd_run(0, 40);
      rnd_run(1, 25);
    join
    tick_n(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
